// File: rtl/issue_pkg.sv
// Shared definitions for the instruction issue controller.
// Contents:
//   issue_state_e - controller FSM state encoding (ST_RUN, ST_TRAP)
//   NOP_INSTR     - canonical RISC-V nop (addi x0, x0, 0), handy as filler
//   DEFAULT_XLEN  - default instruction / PC width
package issue_pkg;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } issue_state_e;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam int unsigned DEFAULT_XLEN = 32;

endpackage

// File: rtl/issue_fifo.sv
// Small {instr, pc} buffer between fetch and decode.
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   flush_i        - synchronous clear of pointers and count; wins over push/pop
//   push_i         - write {instr_i, pc_i} (ignored when full)
//   pop_i          - drop head entry (ignored when empty)
//   instr_i, pc_i  - write data
//   head_instr_o   - instruction at read pointer
//   head_pc_o      - PC at read pointer
//   count_o        - number of valid entries (0..DEPTH)
//   full_o, empty_o
// DEPTH must be a power of two so the pointers wrap naturally.
module issue_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [XLEN-1:0]          instr_i,
    input  logic [XLEN-1:0]          pc_i,
    output logic [XLEN-1:0]          head_instr_o,
    output logic [XLEN-1:0]          head_pc_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    typedef logic [PtrW-1:0] ptr_t;

    logic [XLEN-1:0] instr_mem_q [DEPTH];
    logic [XLEN-1:0] pc_mem_q    [DEPTH];
    ptr_t            wr_ptr_q, wr_ptr_d;
    ptr_t            rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_push, do_pop;

    assign full_o       = (count_q == FullCnt);
    assign empty_o      = (count_q == '0);
    assign count_o      = count_q;
    assign head_instr_o = instr_mem_q[rd_ptr_q];
    assign head_pc_o    = pc_mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count_q gates every read.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            instr_mem_q[wr_ptr_q] <= instr_i;
            pc_mem_q[wr_ptr_q]    <= pc_i;
        end
    end

endmodule

// File: rtl/instr_issue_ctrl.sv
// Issue sequencer between instruction fetch and the combinational decoder.
// Buffers fetched words, presents the head to the decoder, offers legal
// instructions to execute over valid/ready, and turns illegal encodings into
// a trap request. A redirect flushes all buffered words.
// Ports:
//   clk, rst_n                    - clock, asynchronous active-low reset
//   if_valid_i/if_ready_o         - fetch handshake, if_instr_i/if_pc_i payload
//   dec_en_o/dec_instr_o          - decoder enable and instruction code
//   dec_invalid_i                 - decoder illegal flags (any bit set = illegal)
//   ex_valid_o/ex_ready_i/ex_pc_o - execute handshake
//   redirect_valid_i              - control-flow change, flush buffer
//   trap_req_o/trap_pc_o/trap_ack_i - illegal-instruction trap interface
//   perf_issued_o/perf_stall_o    - performance counters
// Configuration macro: ISSUE_PERF_CNT_EN builds the performance counters;
// without it both perf outputs are tied to zero.
module instr_issue_ctrl
    import issue_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned XLEN  = DEFAULT_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid_i,
    output logic            if_ready_o,
    input  logic [XLEN-1:0] if_instr_i,
    input  logic [XLEN-1:0] if_pc_i,
    output logic            dec_en_o,
    output logic [XLEN-1:0] dec_instr_o,
    input  logic [XLEN-1:0] dec_invalid_i,
    output logic            ex_valid_o,
    input  logic            ex_ready_i,
    output logic [XLEN-1:0] ex_pc_o,
    input  logic            redirect_valid_i,
    output logic            trap_req_o,
    output logic [XLEN-1:0] trap_pc_o,
    input  logic            trap_ack_i,
    output logic [31:0]     perf_issued_o,
    output logic [31:0]     perf_stall_o
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    issue_state_e    state_q, state_d;
    logic [XLEN-1:0] trap_pc_q, trap_pc_d;

    logic            fifo_push, fifo_pop, fifo_flush;
    logic [XLEN-1:0] head_instr, head_pc;
    logic [CntW-1:0] fifo_count;
    logic            fifo_full, fifo_empty;
    logic            head_illegal;

    issue_fifo #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (fifo_flush),
        .push_i       (fifo_push),
        .pop_i        (fifo_pop),
        .instr_i      (if_instr_i),
        .pc_i         (if_pc_i),
        .head_instr_o (head_instr),
        .head_pc_o    (head_pc),
        .count_o      (fifo_count),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty)
    );

    assign head_illegal = |dec_invalid_i;
    assign fifo_push    = if_valid_i && if_ready_o;
    assign trap_pc_o    = trap_pc_q;

    always_comb begin
        state_d     = state_q;
        trap_pc_d   = trap_pc_q;
        if_ready_o  = 1'b0;
        dec_en_o    = 1'b0;
        dec_instr_o = '0;
        ex_valid_o  = 1'b0;
        ex_pc_o     = '0;
        trap_req_o  = 1'b0;
        fifo_pop    = 1'b0;
        fifo_flush  = redirect_valid_i;
        unique case (state_q)
            ST_RUN: begin
                // rst_n term keeps fetch stalled while reset is held.
                if_ready_o = rst_n && !fifo_full && !redirect_valid_i;
                if (!fifo_empty) begin
                    dec_en_o    = 1'b1;
                    dec_instr_o = head_instr;
                    if (!head_illegal) begin
                        ex_valid_o = 1'b1;
                        ex_pc_o    = head_pc;
                        fifo_pop   = ex_ready_i;
                    end else if (!redirect_valid_i) begin
                        // A redirect discards the illegal word before it can trap.
                        state_d    = ST_TRAP;
                        trap_pc_d  = head_pc;
                        fifo_flush = 1'b1;
                    end
                end
            end
            ST_TRAP: begin
                trap_req_o = 1'b1;
                if (trap_ack_i) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            trap_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            trap_pc_q <= trap_pc_d;
        end
    end

`ifdef ISSUE_PERF_CNT_EN
    logic [31:0] perf_issued_q, perf_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (ex_valid_o && ex_ready_i)  perf_issued_q <= perf_issued_q + 32'd1;
            if (ex_valid_o && !ex_ready_i) perf_stall_q  <= perf_stall_q + 32'd1;
        end
    end

    assign perf_issued_o = perf_issued_q;
    assign perf_stall_o  = perf_stall_q;
`else
    assign perf_issued_o = '0;
    assign perf_stall_o  = '0;
`endif

    // Occupancy bookkeeping must agree with the full flag.
    assert property (@(posedge clk) disable iff (!rst_n) fifo_full == (fifo_count == FullCnt));

endmodule
